// File: rtl/instr_dispatch_unit.sv
// Instruction dispatch unit: accepts one 32-bit instruction stream and spreads
// it over NUM_CORES first-word-fall-through FIFOs, one FIFO per downstream core.
// The default policy is round-robin that skips full cores.
// Optional macro DISPATCH_AFFINITY_EN: in_instr[31:30] selects the target core.
// That mode needs NUM_CORES == 4.
module instr_dispatch_unit #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [31:0]                  in_instr,
  output logic                         in_ready,
  output logic [32*NUM_CORES-1:0]      core_instr,
  output logic [NUM_CORES-1:0]         core_valid,
  input  logic [NUM_CORES-1:0]         core_ready,
  output logic [CNT_W*NUM_CORES-1:0]   core_count,
  output logic [1:0]                   dispatched_core
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [IDX_W-1:0]     r_rr_ptr;
  logic [1:0]           r_disp;
  logic [NUM_CORES-1:0] w_full;
  logic [NUM_CORES-1:0] w_push;
  logic [NUM_CORES-1:0] w_pop;
  logic [IDX_W-1:0]     w_target;
  logic                 w_found;
  logic                 w_accept;
  logic [IDX_W-1:0]     w_rr_next;

`ifdef DISPATCH_AFFINITY_EN
  // Target core comes from the top two instruction bits.
  // A full target stalls the whole stream, even when other cores have space.
  always_comb begin
    w_target = in_instr[31:30];
    w_found  = !w_full[in_instr[31:30]];
  end
`else
  logic [IDX_W:0] w_scan_idx;

  // Pick the first non-full core, starting at rr_ptr and wrapping modulo NUM_CORES.
  // The scan runs from the highest offset down, so the lowest offset wins.
  always_comb begin
    w_target   = '0;
    w_found    = 1'b0;
    w_scan_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      w_scan_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      if (w_scan_idx >= (IDX_W+1)'(NUM_CORES))
        w_scan_idx = w_scan_idx - (IDX_W+1)'(NUM_CORES);
      if (!w_full[w_scan_idx[IDX_W-1:0]]) begin
        w_target = w_scan_idx[IDX_W-1:0];
        w_found  = 1'b1;
      end
    end
  end
`endif

  assign in_ready        = w_found & ~flush;
  assign w_accept        = in_valid & in_ready;
  assign w_rr_next       = (w_target == IDX_W'(NUM_CORES - 1)) ? '0 : w_target + IDX_W'(1);
  assign dispatched_core = r_disp;

  // Round-robin pointer and last-dispatch register.
  // In affinity mode the pointer is held at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_disp   <= '0;
    end else if (flush) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
`ifndef DISPATCH_AFFINITY_EN
      r_rr_ptr <= w_rr_next;
`endif
      r_disp   <= 2'(w_target);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic [31:0]      r_mem [FIFO_DEPTH];
      logic [PTR_W-1:0] r_wptr;
      logic [PTR_W-1:0] r_rptr;
      logic [CNT_W-1:0] r_count;

      assign w_full[gi]     = (r_count == CNT_W'(FIFO_DEPTH));
      assign core_valid[gi] = (r_count != '0);
      assign w_push[gi]     = w_accept && (w_target == IDX_W'(gi));
      assign w_pop[gi]      = core_valid[gi] & core_ready[gi];
      assign core_instr[32*gi +: 32]       = core_valid[gi] ? r_mem[r_rptr] : 32'h0;
      assign core_count[CNT_W*gi +: CNT_W] = r_count;

      // Entry storage.
      // It has no reset because a stale entry is never visible while the count is zero.
      always_ff @(posedge clock) begin
        if (w_push[gi])
          r_mem[r_wptr] <= in_instr;
      end

      // Pointers and occupancy.
      // When a push and a pop happen together, both pointers move and the count holds.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else if (flush) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_push[gi])
            r_wptr <= r_wptr + PTR_W'(1);
          if (w_pop[gi])
            r_rptr <= r_rptr + PTR_W'(1);
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_instr_dispatch_unit.sv
// Scoreboard bench for instr_dispatch_unit.
// The driver pushes each accepted instruction into its core's expected queue.
// A negedge monitor compares every core pop against the front of that queue.
module tb_instr_dispatch_unit;
  localparam int NC = 4;
  localparam int FD = 4;
  localparam int CW = 3;

  logic              clock = 1'b0;
  logic              reset, flush, in_valid, in_ready;
  logic [31:0]       in_instr;
  logic [32*NC-1:0]  core_instr;
  logic [NC-1:0]     core_valid, core_ready;
  logic [CW*NC-1:0]  core_count;
  logic [1:0]        dispatched_core;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [NC][$];

  instr_dispatch_unit #(.NUM_CORES(NC), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_ready(in_ready), .core_instr(core_instr),
    .core_valid(core_valid), .core_ready(core_ready), .core_count(core_count),
    .dispatched_core(dispatched_core)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    return 32'(core_count[CW*k +: CW]);
  endfunction

  function automatic logic [31:0] head_of(input int k);
    return core_instr[32*k +: 32];
  endfunction

  // Monitor: each valid&ready pop must match the oldest expected entry for that core.
  always @(negedge clock) begin
    if (!reset && !flush) begin
      for (int k = 0; k < NC; k++) begin
        if (core_valid[k] && core_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop core%0d actual=%h required=none", k, head_of(k));
          end else begin
            logic [31:0] e;
            e = exp_q[k].pop_front();
            chk($sformatf("pop_core%0d", k), head_of(k), e);
            $display("pop core%0d data=%h", k, head_of(k));
          end
        end
      end
    end
  end

  // Offer one instruction and wait, with a bound, until it is accepted.
  // Call this at posedge+1. It returns at posedge+1 after the accept.
  task automatic send(input logic [31:0] instr, input int exp_core);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = instr;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout instr=%h actual=stalled required=accepted", instr);
    end else begin
      exp_q[exp_core].push_back(instr);
      $display("send instr=%h core=%0d", instr, dispatched_core);
      chk("dispatched_core", 32'(dispatched_core), exp_core);
    end
  endtask

  // Let every core consume for a while, then check that all queues and FIFOs are empty.
  task automatic drain_and_check();
    core_ready = '1;
    repeat (8) @(posedge clock);
    #1;
    core_ready = '0;
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("drain_q%0d", k), 32'(exp_q[k].size()), 0);
      chk($sformatf("drain_cnt%0d", k), cnt_of(k), 0);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; core_ready = '0;
    #2;
    chk("rst_valid", 32'(core_valid), 0);
    chk("rst_count", 32'(core_count), 0);
    chk("rst_instr_nz", 32'(|core_instr), 0);
    chk("rst_disp", 32'(dispatched_core), 0);
    chk("rst_ready", 32'(in_ready), 1);
    #10 reset = 1'b0;
    @(posedge clock);
    #1;

`ifdef DISPATCH_AFFINITY_EN
    for (int i = 0; i < 4; i++) send(32'hC000_0001, 3);
    chk("aff_cnt3", cnt_of(3), 4);
    fork
      send(32'hC000_0001, 3);
      begin
        @(negedge clock);
        chk("aff_blocked", 32'(in_ready), 0);
        @(posedge clock); #1 core_ready[3] = 1'b1;
        @(posedge clock); #1 core_ready[3] = 1'b0;
      end
    join
    chk("aff_cnt0_before", cnt_of(0), 0);
    send(32'h0000_0002, 0);
    chk("aff_cnt0_after", cnt_of(0), 1);
    drain_and_check();
`else
    // Eight instructions spread round-robin, two per core.
    for (int i = 0; i < 8; i++) send(32'h100 + i, i % 4);
    @(negedge clock);
    chk("rr8_ready", 32'(in_ready), 1);
    for (int k = 0; k < NC; k++) chk($sformatf("rr8_cnt%0d", k), cnt_of(k), 2);
    chk("rr8_head0", head_of(0), 32'h100);
    @(posedge clock); #1;

    // Fill every FIFO; the 17th instruction waits until core 2 frees a slot.
    for (int i = 8; i < 16; i++) send(32'h100 + i, i % 4);
    @(negedge clock);
    chk("full_ready", 32'(in_ready), 0);
    for (int k = 0; k < NC; k++) chk($sformatf("full_cnt%0d", k), cnt_of(k), 4);
    @(posedge clock); #1;
    fork
      send(32'h110, 2);
      begin
        repeat (2) @(posedge clock);
        #1 core_ready[2] = 1'b1;
        @(posedge clock);
        #1 core_ready[2] = 1'b0;
      end
    join
    chk("i17_cnt2", cnt_of(2), 4);
    drain_and_check();

    // Flush while empty resets rr_ptr to 0.
    // Then only core 1 fills while cores 0, 2 and 3 consume; this leaves rr_ptr at 1.
    flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    core_ready = 4'b1101;
    for (int i = 0; i < 17; i++) send(32'h400 + i, i % 4);
    repeat (3) @(posedge clock);
    #1 core_ready = '0;
    chk("skip_cnt1", cnt_of(1), 4);
    chk("skip_cnt2", cnt_of(2), 0);
    send(32'hA, 2);
    send(32'hB, 3);

    // Flush with mixed occupancy {0,4,1,1}.
    // Pops and offers during the flush cycle are discarded.
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hDEAD; core_ready = '1;
    @(negedge clock);
    chk("flush_ready", 32'(in_ready), 0);
    chk("flush_valid_pre", 32'(core_valid), 32'b1110);
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0; core_ready = '0;
    chk("flush_valid_post", 32'(core_valid), 0);
    chk("flush_count_post", 32'(core_count), 0);
    for (int k = 0; k < NC; k++) exp_q[k].delete();
    send(32'h200, 0);

    // Core 0 at count 2 with a pop and a push in the same cycle.
    for (int i = 1; i < 8; i++) send(32'h200 + i, i % 4);
    core_ready[0] = 1'b1;
    send(32'h208, 0);
    core_ready[0] = 1'b0;
    chk("pp_cnt0", cnt_of(0), 2);
    chk("pp_head0", head_of(0), 32'h204);
    drain_and_check();

    // Asynchronous reset in the middle of a cycle clears everything at once.
    send(32'h300, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(core_valid), 0);
    chk("arst_count", 32'(core_count), 0);
    for (int k = 0; k < NC; k++) exp_q[k].delete();
    #5 reset = 1'b0;
`endif

    @(posedge clock); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_dispatch_unit.md
Name: instr_dispatch_unit

Overview:
- Front-end stage directly upstream of the four-core processor array.
- Accepts one 32-bit instruction stream over a valid/ready handshake and distributes instructions across NUM_CORES per-core FIFOs.
- Presents each FIFO head to its core over a per-core valid/ready interface.
- Default policy is round-robin with skip-over of full cores; an optional affinity mode routes by instruction bits.

Parameters:
- NUM_CORES, 4, number of downstream cores; fixed at 4 when DISPATCH_AFFINITY_EN is defined.
- FIFO_DEPTH, 4, entries per core FIFO; must be a power of two and at least 2.
- CNT_W, $clog2(FIFO_DEPTH+1), occupancy counter width.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous clear of all FIFOs and the RR pointer.
- in_valid  input  1  upstream instruction valid.
- in_instr  input  32  upstream instruction.
- in_ready  output  1  dispatcher can accept this cycle.
- core_instr  output  32*NUM_CORES  FIFO head per core; core k occupies bits [32k+31:32k].
- core_valid  output  NUM_CORES  FIFO k non-empty.
- core_ready  input  NUM_CORES  core k consumes head.
- core_count  output  CNT_W*NUM_CORES  occupancy per FIFO.
- dispatched_core  output  2  index of the last core written (registered).

Behaviour:
- Reset (async, active-high):
  - All FIFOs empty; read/write pointers and counts 0.
  - rr_ptr=0; dispatched_core=0.
  - core_valid=0, core_instr=0, core_count=0.
- FIFOs:
  - First-word-fall-through. core_instr slice = head entry when non-empty, else 32'h0.
  - core_valid[k] = (count_k != 0).
  - Pop on core_valid[k] & core_ready[k]. core_ready is ignored while empty (no underflow, count unchanged).
  - Pointers wrap modulo FIFO_DEPTH.
- Full rule: full_k = (count_k == FIFO_DEPTH). A full FIFO is not a push target, even if popped in the same cycle.
- Round-robin target selection (combinational): first k with !full_k, scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
- Handshake:
  - in_ready = at least one FIFO not full, and flush=0.
  - Accept when in_valid & in_ready: push in_instr into the target FIFO, rr_ptr <= target+1 (mod NUM_CORES), dispatched_core <= target.
  - No accept leaves rr_ptr unchanged.
- Simultaneous push and pop on the same non-full FIFO: count unchanged, both pointers advance.
- Latency: an instruction accepted in cycle N is visible on core_instr/core_valid in cycle N+1.
- flush=1:
  - Next edge empties all FIFOs and sets rr_ptr=0; pushes and pops that cycle are discarded.
  - core_valid remains driven from the pre-flush state until that edge.
- Ordering: per-core FIFO order matches acceptance order. There is no cross-core ordering guarantee.
- Reset mid-operation: immediate clear regardless of clock; in-flight instructions are lost.

Optional Feature:
- Macro: DISPATCH_AFFINITY_EN.
- Defined:
  - Target = in_instr[31:30]; round-robin is disabled and rr_ptr is held at 0.
  - in_ready = !full_target & !flush. A full target stalls the stream even if other FIFOs have space (head-of-line blocking is intentional).
  - dispatched_core = in_instr[31:30] on accept.
- Undefined: round-robin as above; in_instr[31:30] is carried as ordinary payload.

Test Plan:
- Reset, then stream 8 instructions 32'h100..32'h107 with all core_ready=0 -> cores 0,1,2,3,0,1,2,3 each hold two entries; core_count=2 for all; core0 head=32'h100; in_ready stays 1.
- Continue with core_ready=0 until 16 accepted -> all counts=4, in_ready=0; 17th instruction held until core_ready[2] pulses once, then it is written to core 2.
- Fill core 1 only (counts 0,4,0,0), rr_ptr=1, push 32'hA -> written to core 2, dispatched_core=2, rr_ptr=3.
- Core 0 at count 2 with core_ready[0]=1 and a simultaneous push to core 0 -> count stays 2, head advances, new entry appears at the tail.
- flush asserted for one cycle with mixed occupancy -> next cycle all core_valid=0, counts=0, rr_ptr=0; in_ready=0 during the flush cycle.
- With DISPATCH_AFFINITY_EN, push 32'hC000_0001 x5 with core_ready[3]=0 -> core 3 count=4, in_ready=0 on the 5th; a 32'h0000_0002 offered next stays blocked behind it.
